// File: rtl/forward_neuron_layer_pkg.sv
// forward_neuron_layer_pkg: shared state encoding, saturation bounds and product alignment
package forward_neuron_layer_pkg;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;
  function automatic int sat_max(input int wv);
    return (1 << (wv - 1)) - 1;
  endfunction
  function automatic int sat_min(input int wv);
    return -(1 << (wv - 1));
  endfunction
  // Q1.(wv-1) product: drop wv-1 fraction bits by floor, keep wv bits
  function automatic int prod_lsb(input int wv);
    return wv - 1;
  endfunction
endpackage

// File: rtl/forward_neuron_layer_fixed_mac_lane.sv
// fixed_mac_lane: one output neuron; signed accumulator plus bias, saturation and activation
module fixed_mac_lane
  import forward_neuron_layer_pkg::*;
#(
  parameter int WV = 4,
  parameter int NP = 4,
  parameter string ACT = "relu"
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [WV-1:0] x,
  input  logic signed [WV-1:0] w,
  input  logic signed [WV-1:0] bias,
  output logic        [WV-1:0] y
);
  localparam int AW = WV + $clog2(NP + 1) + 1;
  localparam int PL = prod_lsb(WV);
  localparam bit RELU = ACT == "relu";
  localparam logic signed [AW:0] SMAX = (AW + 1)'(sat_max(WV));
  localparam logic signed [AW:0] SMIN = (AW + 1)'(sat_min(WV));
  logic signed [AW-1:0] acc;
  logic signed [2*WV-1:0] prod;
  logic signed [WV-1:0] term;
  logic signed [AW:0] s;
  logic [WV-1:0] sat;
  assign prod = x * w;
  assign term = prod[PL +: WV];
  assign s = (AW + 1)'(acc) + (AW + 1)'(bias);
  assign sat = s > SMAX ? SMAX[WV-1:0] : s < SMIN ? SMIN[WV-1:0] : s[WV-1:0];
  assign y = RELU && s < 0 ? '0 : sat;
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc + AW'(term);
endmodule

// File: rtl/forward_neuron_layer.sv
// forward_neuron_layer: joins a state vector with a weight/bias bundle, runs an NP-step MAC
// over NC parallel lanes and offers the activated result on a valid/ready master port.
module forward_neuron_layer
  import forward_neuron_layer_pkg::*;
#(
  parameter int NP = 4,
  parameter int NC = 4,
  parameter int WV = 4,
  parameter string ACT = "relu"
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic                        iValid_AS_State0,
  output logic                        oReady_AS_State0,
  input  logic [NP*WV-1:0]            iData_AS_State0,
  input  logic                        iValid_AS_WeightBias,
  output logic                        oReady_AS_WeightBias,
  input  logic [NP*NC*WV+NC*WV-1:0]   iData_AS_WeightBias,
  output logic                        oValid_BM_State1,
  input  logic                        iReady_BM_State1,
  output logic [NC*WV-1:0]            oData_BM_State1
);
  localparam int CW = NP > 1 ? $clog2(NP) : 1;
  state_e state;
  logic [CW-1:0] cnt;
  logic [NP*WV-1:0] x_r;
  logic [NP*NC*WV+NC*WV-1:0] wb_r;
  logic [NC*WV-1:0] y;
  logic join_go;
  assign join_go = state == IDLE && iValid_AS_State0 && iValid_AS_WeightBias;
  assign oReady_AS_State0 = join_go;
  assign oReady_AS_WeightBias = join_go;
  // OUT spends its first cycle registering the lane results, then waits for the handshake
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      state <= IDLE;
      cnt <= '0;
      x_r <= '0;
      wb_r <= '0;
      oValid_BM_State1 <= 1'b0;
      oData_BM_State1 <= '0;
    end else begin
      case (state)
        IDLE: if (join_go) begin
          x_r <= iData_AS_State0;
          wb_r <= iData_AS_WeightBias;
          cnt <= '0;
          state <= MAC;
        end
        MAC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NP - 1)) state <= OUT;
        end
        OUT: if (!oValid_BM_State1) begin
          oValid_BM_State1 <= 1'b1;
          oData_BM_State1 <= y;
        end else if (iReady_BM_State1) begin
          oValid_BM_State1 <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  for (genvar c = 0; c < NC; c++) begin : g_lane
    fixed_mac_lane #(.WV(WV), .NP(NP), .ACT(ACT)) u_lane (
      .iCLK(iCLK),
      .iRST(iRST),
      .clr(join_go),
      .en(state == MAC),
      .x(x_r[int'(cnt) * WV +: WV]),
      .w(wb_r[NC * WV + (int'(cnt) * NC + c) * WV +: WV]),
      .bias(wb_r[c * WV +: WV]),
      .y(y[c * WV +: WV])
    );
  end
endmodule
